// File: rtl/axis_probe_stepper.sv
// -----------------------------------------------------------------------------
// axis_probe_stepper
//
// Purpose:
//   Steps an external DUT through a fixed number of clock cycles under
//   AXI-Stream control.
//   1. A request packet supplies a cycle count N and a set of DUT input words.
//   2. The block applies the input words and enables the DUT clock for N cycles.
//   3. It waits a short settling delay and then snapshots the DUT outputs.
//   4. It returns the snapshot as a response packet.
//
// Ports:
//   s_axis_aclk / s_axis_aresetn : single clock, asynchronous active-low reset
//   s_axis_*                     : request stream
//                                  (header word, then VIP2DUT_WORDS_NUM payload words)
//   m_axis_*                     : response stream (DUT2VIP_WORDS_NUM words)
//   dut2vip_bus                  : DUT outputs, sampled in the capture cycle
//   vip2dut_bus                  : registered DUT inputs; updated only when a
//                                  good packet completes
//   vip2dut_clk_en               : enable for an external glitch-free clock gate
//   bad_packet_cnt               : saturating count of discarded request packets
//   busy                         : high whenever a request is being processed
// -----------------------------------------------------------------------------
module axis_probe_stepper #(
    parameter int C_DATA_WIDTH      = 128,
    parameter int VIP2DUT_WORDS_NUM = 10,
    parameter int DUT2VIP_WORDS_NUM = 10,
    parameter int CLK_CNT_WIDTH     = 16,
    parameter int CAPTURE_DELAY     = 1
) (
    input  logic                                      s_axis_aclk,
    input  logic                                      s_axis_aresetn,
    input  logic                                      s_axis_tvalid,
    output logic                                      s_axis_tready,
    input  logic [C_DATA_WIDTH-1:0]                   s_axis_tdata,
    input  logic [C_DATA_WIDTH/8-1:0]                 s_axis_tkeep,
    input  logic                                      s_axis_tlast,
    output logic                                      m_axis_tvalid,
    input  logic                                      m_axis_tready,
    output logic [C_DATA_WIDTH-1:0]                   m_axis_tdata,
    output logic [C_DATA_WIDTH/8-1:0]                 m_axis_tkeep,
    output logic                                      m_axis_tlast,
    input  logic [C_DATA_WIDTH*DUT2VIP_WORDS_NUM-1:0] dut2vip_bus,
    output logic [C_DATA_WIDTH*VIP2DUT_WORDS_NUM-1:0] vip2dut_bus,
    output logic                                      vip2dut_clk_en,
    output logic [15:0]                               bad_packet_cnt,
    output logic                                      busy
);

    localparam int W   = C_DATA_WIDTH;
    localparam int WIW = $clog2(VIP2DUT_WORDS_NUM + 2);
    localparam int RIW = $clog2(DUT2VIP_WORDS_NUM + 1);
    localparam int DCW = $clog2(CAPTURE_DELAY + 1);

    localparam logic [WIW-1:0] LAST_IDX   = WIW'(VIP2DUT_WORDS_NUM);
    // Sticky "too long" index: once reached, the packet can only be discarded.
    localparam logic [WIW-1:0] OVER_IDX   = WIW'(VIP2DUT_WORDS_NUM + 1);
    localparam logic [RIW-1:0] RESP_LAST  = RIW'(DUT2VIP_WORDS_NUM - 1);
    localparam logic [DCW-1:0] DELAY_LAST = DCW'(CAPTURE_DELAY - 1);

    typedef enum logic [2:0] {
        ST_RECV,
        ST_RUN,
        ST_WAIT,
        ST_CAPT,
        ST_SEND
    } state_t;

    state_t                           state_q, state_d;
    logic                             rdy_q, rdy_d;
    logic [WIW-1:0]                   word_idx_q, word_idx_d;
    logic [CLK_CNT_WIDTH-1:0]         hdr_n_q, hdr_n_d;
    logic [CLK_CNT_WIDTH-1:0]         cyc_cnt_q, cyc_cnt_d;
    logic [DCW-1:0]                   dly_cnt_q, dly_cnt_d;
    logic [RIW-1:0]                   resp_idx_q, resp_idx_d;
    logic [15:0]                      bad_cnt_q, bad_cnt_d;
    logic [W*VIP2DUT_WORDS_NUM-1:0]   bus_q, bus_d;
    logic [W*VIP2DUT_WORDS_NUM-1:0]   stage_flat;
    logic [W-1:0]                     stage_q [VIP2DUT_WORDS_NUM];
    logic [W-1:0]                     obuf_q  [DUT2VIP_WORDS_NUM];
    logic                             s_hs;
    logic                             m_hs;
    logic                             unused_tkeep;

    assign unused_tkeep = ^s_axis_tkeep;

    // rdy_q keeps tready low through reset and raises it on the first edge
    // after release.
    assign s_axis_tready  = (state_q == ST_RECV) && rdy_q;
    assign s_hs           = s_axis_tvalid && s_axis_tready;
    assign m_axis_tvalid  = (state_q == ST_SEND);
    assign m_hs           = m_axis_tvalid && m_axis_tready;
    assign m_axis_tlast   = m_axis_tvalid && (resp_idx_q == RESP_LAST);
    assign m_axis_tkeep   = '1;
    assign vip2dut_clk_en = (state_q == ST_RUN);
    assign busy           = (state_q != ST_RECV);
    assign vip2dut_bus    = bus_q;
    assign bad_packet_cnt = bad_cnt_q;

    genvar gi;

    // Payload word k (stream index k+1) lands in slot k. The last slot is
    // taken straight from the bus when the final word arrives, so the DUT
    // inputs are updated in the cycle right after the tlast handshake.
    generate
        for (gi = 0; gi < VIP2DUT_WORDS_NUM; gi++) begin : g_stage
            localparam logic [WIW-1:0] SLOT_IDX = WIW'(gi + 1);
            always_ff @(posedge s_axis_aclk) begin
                if (s_hs && (word_idx_q == SLOT_IDX)) begin
                    stage_q[gi] <= s_axis_tdata;
                end
            end
            if (gi == VIP2DUT_WORDS_NUM - 1) begin : g_last
                assign stage_flat[gi*W +: W] = s_axis_tdata;
            end else begin : g_mid
                assign stage_flat[gi*W +: W] = stage_q[gi];
            end
        end

        for (gi = 0; gi < DUT2VIP_WORDS_NUM; gi++) begin : g_obuf
            always_ff @(posedge s_axis_aclk) begin
                if (state_q == ST_CAPT) begin
                    obuf_q[gi] <= dut2vip_bus[gi*W +: W];
                end
            end
        end
    endgenerate

    always_comb begin
        m_axis_tdata = '0;
        for (int k = 0; k < DUT2VIP_WORDS_NUM; k++) begin
            if (resp_idx_q == RIW'(k)) begin
                m_axis_tdata = obuf_q[k];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        rdy_d      = 1'b1;
        word_idx_d = word_idx_q;
        hdr_n_d    = hdr_n_q;
        cyc_cnt_d  = cyc_cnt_q;
        dly_cnt_d  = dly_cnt_q;
        resp_idx_d = resp_idx_q;
        bad_cnt_d  = bad_cnt_q;
        bus_d      = bus_q;
        case (state_q)
            ST_RECV: begin
                if (s_hs) begin
                    if (word_idx_q == '0) begin
                        hdr_n_d = s_axis_tdata[CLK_CNT_WIDTH-1:0];
                    end
                    if (s_axis_tlast) begin
                        word_idx_d = '0;
                        if (word_idx_q == LAST_IDX) begin
                            bus_d     = stage_flat;
                            cyc_cnt_d = hdr_n_q;
                            dly_cnt_d = '0;
                            state_d   = (hdr_n_q != '0) ? ST_RUN : ST_WAIT;
                        end else if (bad_cnt_q != 16'hFFFF) begin
                            bad_cnt_d = bad_cnt_q + 16'd1;
                        end
                    end else if (word_idx_q != OVER_IDX) begin
                        word_idx_d = word_idx_q + 1'b1;
                    end
                end
            end
            ST_RUN: begin
                cyc_cnt_d = cyc_cnt_q - 1'b1;
                if (cyc_cnt_q == CLK_CNT_WIDTH'(1)) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (dly_cnt_q == DELAY_LAST) begin
                    state_d = ST_CAPT;
                end else begin
                    dly_cnt_d = dly_cnt_q + 1'b1;
                end
            end
            ST_CAPT: begin
                resp_idx_d = '0;
                state_d    = ST_SEND;
            end
            ST_SEND: begin
                if (m_hs) begin
                    if (resp_idx_q == RESP_LAST) begin
                        state_d = ST_RECV;
                    end else begin
                        resp_idx_d = resp_idx_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_RECV;
        endcase
    end

    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            state_q    <= ST_RECV;
            rdy_q      <= 1'b0;
            word_idx_q <= '0;
            hdr_n_q    <= '0;
            cyc_cnt_q  <= '0;
            dly_cnt_q  <= '0;
            resp_idx_q <= '0;
            bad_cnt_q  <= '0;
            bus_q      <= '0;
        end else begin
            state_q    <= state_d;
            rdy_q      <= rdy_d;
            word_idx_q <= word_idx_d;
            hdr_n_q    <= hdr_n_d;
            cyc_cnt_q  <= cyc_cnt_d;
            dly_cnt_q  <= dly_cnt_d;
            resp_idx_q <= resp_idx_d;
            bad_cnt_q  <= bad_cnt_d;
            bus_q      <= bus_d;
        end
    end

endmodule

// File: tb/tb_axis_probe_stepper.sv
module tb_axis_probe_stepper;

    localparam int W   = 128;
    localparam int VIP = 2;
    localparam int D2V = 3;
    localparam int CW  = 16;
    localparam int CD  = 2;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 s_tvalid = 1'b0;
    logic                 s_tready;
    logic [W-1:0]         s_tdata = '0;
    logic [W/8-1:0]       s_tkeep = '0;
    logic                 s_tlast = 1'b0;
    logic                 m_tvalid;
    logic                 m_tready = 1'b0;
    logic [W-1:0]         m_tdata;
    logic [W/8-1:0]       m_tkeep;
    logic                 m_tlast;
    logic [W*D2V-1:0]     d2v = '0;
    logic [W*VIP-1:0]     v2d;
    logic                 clk_en;
    logic [15:0]          bad_cnt;
    logic                 busy;

    int errors = 0;
    int checks = 0;

    // Reference state: what the DUT input bus and the discard counter should hold.
    logic [W*VIP-1:0]     model_bus = '0;
    int                   model_bad = 0;

    always #5 clk = ~clk;

    axis_probe_stepper #(
        .C_DATA_WIDTH(W), .VIP2DUT_WORDS_NUM(VIP), .DUT2VIP_WORDS_NUM(D2V),
        .CLK_CNT_WIDTH(CW), .CAPTURE_DELAY(CD)
    ) dut (
        .s_axis_aclk(clk), .s_axis_aresetn(rst_n),
        .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready), .s_axis_tdata(s_tdata),
        .s_axis_tkeep(s_tkeep), .s_axis_tlast(s_tlast),
        .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready), .m_axis_tdata(m_tdata),
        .m_axis_tkeep(m_tkeep), .m_axis_tlast(m_tlast),
        .dut2vip_bus(d2v), .vip2dut_bus(v2d), .vip2dut_clk_en(clk_en),
        .bad_packet_cnt(bad_cnt), .busy(busy)
    );

    function automatic logic [W-1:0] rand_word();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Advance one clock; DUT outputs change every cycle so a snapshot is meaningful.
    task automatic step();
        for (int i = 0; i < W*D2V/32; i++) d2v[i*32 +: 32] = $urandom;
        @(posedge clk);
        #1;
    endtask

    // Sends nw words (tlast on the last) with random idle gaps, then updates the model.
    task automatic send_packet(input int nw, input logic [CW-1:0] n);
        logic [W-1:0] pay [VIP];
        for (int i = 0; i < nw; i++) begin
            if ($urandom_range(3) == 0) begin
                s_tvalid = 1'b0;
                step();
            end
            s_tvalid = 1'b1;
            s_tdata  = rand_word();
            if (i == 0) s_tdata[CW-1:0] = n;
            s_tkeep  = W/8'($urandom);
            s_tlast  = (i == nw - 1);
            if (i >= 1 && i <= VIP) pay[i-1] = s_tdata;
            checks++;
            if (s_tready !== 1'b1) begin errors++; $display("FAIL s_tready_in_packet word %0d: got %b want 1", i, s_tready); end
            checks++;
            if (v2d !== model_bus) begin errors++; $display("FAIL vip2dut_held word %0d: got %h want %h", i, v2d, model_bus); end
            step();
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        if (nw == VIP + 1) begin
            for (int k = 0; k < VIP; k++) model_bus[k*W +: W] = pay[k];
        end else if (model_bad < 16'hFFFF) begin
            model_bad++;
        end
    endtask

    // After a discarded packet: counter bumped, still ready, nothing runs or responds.
    task automatic check_discard(input string tag);
        checks++;
        if (bad_cnt !== 16'(model_bad)) begin errors++; $display("FAIL %s bad_cnt: got %0d want %0d", tag, bad_cnt, model_bad); end
        for (int c = 0; c < 8; c++) begin
            checks++;
            if (s_tready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL %s idle cyc %0d: tready=%b busy=%b want 1/0", tag, c, s_tready, busy); end
            checks++;
            if (clk_en !== 1'b0 || m_tvalid !== 1'b0) begin errors++; $display("FAIL %s quiet cyc %0d: clk_en=%b tvalid=%b want 0/0", tag, c, clk_en, m_tvalid); end
            checks++;
            if (v2d !== model_bus) begin errors++; $display("FAIL %s vip2dut_unchanged: got %h want %h", tag, v2d, model_bus); end
            step();
        end
        $display("%s: discarded, bad_cnt=%0d", tag, bad_cnt);
    endtask

    // After a good packet: N enabled cycles, then the snapshot comes back
    // 1 + N + CD + 1 cycles after the tlast handshake.
    task automatic check_response(input string tag, input int n);
        int              cyc;
        int              idx;
        int              guard;
        bit              hs;
        logic [W*D2V-1:0] snap;
        checks++;
        if (v2d !== model_bus) begin errors++; $display("FAIL %s vip2dut_applied: got %h want %h", tag, v2d, model_bus); end
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL %s busy: got %b want 1", tag, busy); end
        cyc = 1;
        while (m_tvalid !== 1'b1 && cyc < n + CD + 10) begin
            checks++;
            if (clk_en !== (cyc <= n)) begin errors++; $display("FAIL %s clk_en cyc %0d: got %b want %b", tag, cyc, clk_en, cyc <= n); end
            checks++;
            if (s_tready !== 1'b0) begin errors++; $display("FAIL %s tready_busy cyc %0d: got %b want 0", tag, cyc, s_tready); end
            step();
            cyc++;
        end
        checks++;
        if (m_tvalid !== 1'b1 || cyc != n + CD + 2) begin
            errors++;
            $display("FAIL %s latency: got %0d (tvalid=%b) want %0d", tag, cyc, m_tvalid, n + CD + 2);
            return;
        end
        snap  = d2v;
        idx   = 0;
        guard = 0;
        while (idx < D2V && guard < 200) begin
            checks++;
            if (m_tvalid !== 1'b1 || m_tdata !== snap[idx*W +: W]) begin errors++; $display("FAIL %s tdata[%0d]: got %h (v=%b) want %h", tag, idx, m_tdata, m_tvalid, snap[idx*W +: W]); end
            checks++;
            if (m_tlast !== (idx == D2V - 1) || m_tkeep !== '1) begin errors++; $display("FAIL %s tlast/tkeep[%0d]: got %b/%h want %b/all-ones", tag, idx, m_tlast, m_tkeep, idx == D2V - 1); end
            checks++;
            if (s_tready !== 1'b0 || clk_en !== 1'b0) begin errors++; $display("FAIL %s send_side[%0d]: tready=%b clk_en=%b want 0/0", tag, idx, s_tready, clk_en); end
            m_tready = 1'($urandom_range(1));
            hs = m_tready;
            step();
            if (hs) idx++;
            guard++;
        end
        m_tready = 1'b0;
        checks++;
        if (idx != D2V) begin errors++; $display("FAIL %s drain_timeout: got %0d words want %0d", tag, idx, D2V); end
        checks++;
        if (m_tvalid !== 1'b0 || s_tready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL %s back_to_recv: tvalid=%b tready=%b busy=%b want 0/1/0", tag, m_tvalid, s_tready, busy); end
        $display("%s: N=%0d latency=%0d words=%0d", tag, n, cyc, idx);
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (s_tready !== 1'b0 || m_tvalid !== 1'b0 || m_tlast !== 1'b0) begin errors++; $display("FAIL reset_handshake: tready=%b tvalid=%b tlast=%b want 0/0/0", s_tready, m_tvalid, m_tlast); end
        checks++;
        if (clk_en !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL reset_ctrl: clk_en=%b busy=%b want 0/0", clk_en, busy); end
        checks++;
        if (v2d !== '0 || bad_cnt !== 16'd0) begin errors++; $display("FAIL reset_regs: bus=%h bad=%0d want 0/0", v2d, bad_cnt); end
        step();
        step();
        rst_n = 1'b1;
        #1;
        checks++;
        if (s_tready !== 1'b0) begin errors++; $display("FAIL reset_release_tready: got %b want 0", s_tready); end
        step();
        checks++;
        if (s_tready !== 1'b1) begin errors++; $display("FAIL reset_first_edge_tready: got %b want 1", s_tready); end
        $display("test_reset: tready=%b after first edge", s_tready);
    endtask

    task automatic test_basic();
        send_packet(VIP + 1, 16'd3);
        check_response("test_basic", 3);
    endtask

    task automatic test_zero_n();
        send_packet(VIP + 1, 16'd0);
        check_response("test_zero_n", 0);
    endtask

    task automatic test_early_tlast();
        send_packet(VIP, 16'd5);
        check_discard("test_early_tlast");
        send_packet(VIP + 1, 16'd2);
        check_response("test_early_tlast_recover", 2);
    endtask

    task automatic test_long_packet();
        send_packet(VIP + 3, 16'd4);
        check_discard("test_long_packet");
    endtask

    task automatic test_back_to_back();
        for (int t = 0; t < 14; t++) begin
            int kind;
            int nw;
            int n;
            kind = $urandom_range(9);
            n    = $urandom_range(0, 7);
            if (kind == 0)      nw = $urandom_range(1, VIP);
            else if (kind == 1) nw = VIP + 1 + $urandom_range(1, 3);
            else                nw = VIP + 1;
            send_packet(nw, 16'(n));
            if (nw == VIP + 1) check_response("test_back_to_back", n);
            else               check_discard("test_back_to_back");
        end
    endtask

    task automatic test_reset_in_run();
        send_packet(VIP + 1, 16'd10);
        for (int c = 0; c < 3; c++) step();
        checks++;
        if (clk_en !== 1'b1) begin errors++; $display("FAIL run_before_reset clk_en: got %b want 1", clk_en); end
        rst_n = 1'b0;
        #1;
        model_bus = '0;
        model_bad = 0;
        checks++;
        if (clk_en !== 1'b0 || m_tvalid !== 1'b0 || s_tready !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL run_reset_immediate: clk_en=%b tvalid=%b tready=%b busy=%b want 0", clk_en, m_tvalid, s_tready, busy); end
        checks++;
        if (v2d !== '0 || bad_cnt !== 16'd0) begin errors++; $display("FAIL run_reset_regs: bus=%h bad=%0d want 0/0", v2d, bad_cnt); end
        step();
        step();
        rst_n = 1'b1;
        step();
        checks++;
        if (s_tready !== 1'b1) begin errors++; $display("FAIL run_reset_tready: got %b want 1", s_tready); end
        for (int c = 0; c < 20; c++) begin
            checks++;
            if (m_tvalid !== 1'b0 || clk_en !== 1'b0) begin errors++; $display("FAIL run_reset_abandon cyc %0d: tvalid=%b clk_en=%b want 0/0", c, m_tvalid, clk_en); end
            step();
        end
        $display("test_reset_in_run: transaction abandoned, tready=%b", s_tready);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_n();
        test_early_tlast();
        test_long_packet();
        test_back_to_back();
        test_reset_in_run();
        test_basic();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
